serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 151 +++++++++++++++
 tb/tb_serial_subtractor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one full-subtractor cell + borrow FF.
// Latency: operands accepted at edge T, out_valid from edge T+WIDTH+1; one operation in flight at a time.
// Backpressure: in_ready low outside IDLE; result held stable in DONE until out_ready. Option: SERIAL_SUB_OVF_EN adds ovf.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic             r_br;
   logic             r_live;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             w_accept;
   logic             w_last;
   logic             w_d;
   logic             w_br_next;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_ovf;
`endif

   // Full-subtractor cell on the current LSBs plus the running borrow.
   assign w_d       = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
   assign w_br_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
   // All WIDTH bits have been processed once the counter reaches WIDTH.
   assign w_last    = (r_cnt == CW'(WIDTH));
   assign w_accept  = in_valid && in_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state; in_ready is additionally gated until the first edge after reset.
   always_comb begin
      in_ready  = r_live && (r_state == S_IDLE);
      out_valid = (r_state == S_DONE);
      diff      = r_diff;
      bout      = r_bout;
`ifdef SERIAL_SUB_OVF_EN
      ovf       = r_ovf;
`endif
   end

   // Goes high on the first clock edge after reset is released and stays high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   // Datapath: capture at acceptance, shift one bit per RUN cycle, publish result on entry to DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_res   <= '0;
         r_br    <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_br    <= bin;
                  r_res   <= '0;
                  r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                  r_a_msb <= a[WIDTH-1];
                  r_b_msb <= b[WIDTH-1];
`endif
               end
            end
            S_RUN: begin
               if (!w_last) begin
                  r_a_sh <= r_a_sh >> 1;
                  r_b_sh <= r_b_sh >> 1;
                  r_br   <= w_br_next;
                  r_res  <= {w_d, r_res[WIDTH-1:1]};
                  r_cnt  <= r_cnt + CW'(1);
               end else begin
                  // Result register now holds the full difference, LSB at bit 0.
                  r_diff <= r_res;
                  r_bout <= r_br;
`ifdef SERIAL_SUB_OVF_EN
                  r_ovf  <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4.
// Stimulus and sampling are aligned to the falling clock edge.
// Define SERIAL_SUB_OVF_EN to also exercise the overflow flag.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       bin;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] diff;
   logic       bout;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Present one operation, return latency (edges from acceptance to out_valid),
   // plus diff and in_ready seen on the first cycle after acceptance.
   task automatic send(input logic [3:0] ta, input logic [3:0] tbv, input logic tbin,
                       input bit scramble, output int lat,
                       output logic [3:0] diff_run, output logic rdy_run);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      a = ta;
      b = tbv;
      bin = tbin;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      diff_run = diff;
      rdy_run = in_ready;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (scramble) begin
            a = 4'($urandom);
            b = 4'($urandom);
            bin = 1'($urandom);
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      bin = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (diff !== 4'h0) begin errors++; $display("FAIL reset_diff: got %h expected 0", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b expected 0 before first edge", in_ready); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_edge_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_basic();
      int lat;
      logic [3:0] dr;
      logic rr;
      send(4'd9, 4'd3, 1'b0, 1'b0, lat, dr, rr);
      checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
      checks++; if (rr !== 1'b0) begin errors++; $display("FAIL basic_ready_in_run: got %b expected 0", rr); end
      checks++; if (diff !== 4'd6) begin errors++; $display("FAIL basic_diff: got %h expected 6", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic_bout: got %b expected 0", bout); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b expected 0", in_ready); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after_hs: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_hs: got %b expected 1", in_ready); end
   endtask

   task automatic test_vectors();
      logic [3:0] va [3] = '{4'd3, 4'd0, 4'd5};
      logic [3:0] vb [3] = '{4'd9, 4'd0, 4'd5};
      logic       vi [3] = '{1'b0, 1'b1, 1'b0};
      logic [3:0] vd [3] = '{4'hA, 4'hF, 4'h0};
      logic       vo [3] = '{1'b1, 1'b1, 1'b0};
      logic [3:0] prev;
      int lat;
      logic [3:0] dr;
      logic rr;
      prev = 4'd6;
      for (int i = 0; i < 3; i++) begin
         send(va[i], vb[i], vi[i], 1'b0, lat, dr, rr);
         checks++; if (dr !== prev) begin errors++; $display("FAIL vec%0d_diff_held: got %h expected %h", i, dr, prev); end
         checks++; if (diff !== vd[i]) begin errors++; $display("FAIL vec%0d_diff: got %h expected %h", i, diff, vd[i]); end
         checks++; if (bout !== vo[i]) begin errors++; $display("FAIL vec%0d_bout: got %b expected %b", i, bout, vo[i]); end
         prev = vd[i];
         release_result();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [3:0] dr;
      logic rr;
      send(4'd8, 4'd1, 1'b0, 1'b0, lat, dr, rr);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_valid: got %b expected 1", i, out_valid); end
         checks++; if (diff !== 4'd7) begin errors++; $display("FAIL bp%0d_diff: got %h expected 7", i, diff); end
         checks++; if (bout !== 1'b0) begin errors++; $display("FAIL bp%0d_bout: got %b expected 0", i, bout); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      logic [3:0] dr;
      logic rr;
      a = 4'd12;
      b = 4'd4;
      bin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
      checks++; if (diff !== 4'h0) begin errors++; $display("FAIL midrst_diff: got %h expected 0", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout: got %b expected 0", bout); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(4'd2, 4'd1, 1'b0, 1'b0, lat, dr, rr);
      checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 5", lat); end
      checks++; if (diff !== 4'd1) begin errors++; $display("FAIL midrst_next_diff: got %h expected 1", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_next_bout: got %b expected 0", bout); end
      release_result();
   endtask

   task automatic test_operand_hold();
      int lat;
      logic [3:0] dr;
      logic rr;
      send(4'd10, 4'd6, 1'b0, 1'b1, lat, dr, rr);
      checks++; if (diff !== 4'd4) begin errors++; $display("FAIL hold_diff: got %h expected 4", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL hold_bout: got %b expected 0", bout); end
      release_result();
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      logic [3:0] va [3] = '{4'h7, 4'h8, 4'h5};
      logic [3:0] vb [3] = '{4'hF, 4'h1, 4'h2};
      logic [3:0] vd [3] = '{4'h8, 4'h7, 4'h3};
      logic       vo [3] = '{1'b1, 1'b0, 1'b0};
      logic       vv [3] = '{1'b1, 1'b1, 1'b0};
      int lat;
      logic [3:0] dr;
      logic rr;
      for (int i = 0; i < 3; i++) begin
         send(va[i], vb[i], 1'b0, 1'b0, lat, dr, rr);
         checks++; if (diff !== vd[i]) begin errors++; $display("FAIL ovf%0d_diff: got %h expected %h", i, diff, vd[i]); end
         checks++; if (bout !== vo[i]) begin errors++; $display("FAIL ovf%0d_bout: got %b expected %b", i, bout, vo[i]); end
         checks++; if (ovf !== vv[i]) begin errors++; $display("FAIL ovf%0d_flag: got %b expected %b", i, ovf, vv[i]); end
         release_result();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_backpressure();
      test_reset_mid_run();
      test_operand_hold();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
